// File: rtl/netwalk_pkt_header_assembler.sv
// rtl/netwalk_pkt_header_assembler.sv - assembles {len, meta, header words} from FWFT ingress words
module netwalk_pkt_header_assembler #(
    parameter int          DATA_W        = 128,
    parameter int          HDR_WORDS     = 4,
    parameter logic [63:0] META          = 64'hFFFF_FFFF_FFFF_FFFF,
    parameter logic [31:0] MIN_FRAME_LEN = 32'd60,
    localparam int         PAY_W         = DATA_W * HDR_WORDS,
    localparam int         HDR_W         = 32 + 64 + PAY_W
) (
    input  logic              dpl_clk,
    input  logic              dpl_reset_n,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              in_empty_i,
    output logic              in_rd_o,
    output logic [HDR_W-1:0]  hdr_data_o,
    output logic              hdr_empty_o,
    input  logic              hdr_rd_i,
    output logic [2:0]        beat_cnt_o,
    output logic [31:0]       pkt_cnt_o
);

    logic [2:0]       beat_cnt;
    logic [PAY_W-1:0] words_q;
    logic [PAY_W-1:0] words_next;
    logic [31:0]      len_q;
    logic [31:0]      len_calc;
    logic [31:0]      len_now;
    logic [15:0]      ethertype;
    logic             last_beat;
    logic             pop;

    assign last_beat  = (beat_cnt == 3'(HDR_WORDS - 1));
    assign pop        = dpl_reset_n & ~in_empty_i & ~(last_beat & ~hdr_empty_o & ~hdr_rd_i);
    assign in_rd_o    = pop;
    assign beat_cnt_o = beat_cnt;

    // Ethertype lives in bytes 12-13 of word 0, which sits in the MSB slot.
    assign ethertype = words_q[PAY_W-1-96 -: 16];

    // Evaluated while word 1 is at the FIFO head; only captured on that pop.
    always_comb begin
        len_calc = MIN_FRAME_LEN;
        if (ethertype == 16'h0800) begin
            len_calc = {16'd0, in_data_i[DATA_W-1 -: 16] + 16'd14};
        end else if (ethertype == 16'h8847) begin
            len_calc = {16'd0, in_data_i[DATA_W-33 -: 16] + 16'd18};
        end
    end

    // With HDR_WORDS=2 word 1 is also the last beat, so the length bypasses len_q.
    assign len_now = (beat_cnt == 3'd1) ? len_calc : len_q;

    always_comb begin
        words_next = words_q;
        for (int i = 0; i < HDR_WORDS; i++) begin
            if (pop && (beat_cnt == 3'(i))) begin
                words_next[(HDR_WORDS-1-i)*DATA_W +: DATA_W] = in_data_i;
            end
        end
    end

    always_ff @(posedge dpl_clk) begin
        if (!dpl_reset_n) begin
            beat_cnt    <= 3'd0;
            words_q     <= '0;
            len_q       <= 32'd0;
            hdr_data_o  <= '0;
            hdr_empty_o <= 1'b1;
            pkt_cnt_o   <= 32'd0;
        end else begin
            if (pop) begin
                words_q  <= words_next;
                beat_cnt <= last_beat ? 3'd0 : beat_cnt + 3'd1;
                if (beat_cnt == 3'd1) begin
                    len_q <= len_calc;
                end
            end
            // A load takes priority over a consume in the same cycle.
            if (pop && last_beat) begin
                hdr_data_o  <= {len_now, META, words_next};
                hdr_empty_o <= 1'b0;
                pkt_cnt_o   <= pkt_cnt_o + 32'd1;
            end else if (hdr_rd_i && !hdr_empty_o) begin
                hdr_empty_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_netwalk_pkt_header_assembler.sv
// tb/tb_netwalk_pkt_header_assembler.sv - directed bench with packet-level reference model
module tb_netwalk_pkt_header_assembler;

    localparam int HDR_WORDS = 4;

    logic           clk = 1'b0;
    logic           dpl_reset_n = 1'b0;
    logic [127:0]   in_data_i = '0;
    logic           in_empty_i = 1'b1;
    logic           in_rd_o;
    logic [607:0]   hdr_data_o;
    logic           hdr_empty_o;
    logic           hdr_rd_i = 1'b0;
    logic [2:0]     beat_cnt_o;
    logic [31:0]    pkt_cnt_o;

    netwalk_pkt_header_assembler dut (
        .dpl_clk     (clk),
        .dpl_reset_n (dpl_reset_n),
        .in_data_i   (in_data_i),
        .in_empty_i  (in_empty_i),
        .in_rd_o     (in_rd_o),
        .hdr_data_o  (hdr_data_o),
        .hdr_empty_o (hdr_empty_o),
        .hdr_rd_i    (hdr_rd_i),
        .beat_cnt_o  (beat_cnt_o),
        .pkt_cnt_o   (pkt_cnt_o)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] W0   = 128'h005056a5644d0050569a78c708004500;
    localparam logic [127:0] W1   = 128'h0064310e000040116a260ad864d30ad8;
    localparam logic [127:0] W2   = 128'h64d206a506a500500000000300000000;
    localparam logic [127:0] W3   = 128'h0bb800000000ffffffffffff00000000;
    localparam logic [127:0] W0A  = 128'h005056a5644d0050569a78c708064500;
    localparam logic [127:0] W0M  = 128'h005056a5644d0050569a78c788474500;
    localparam logic [127:0] W1M  = 128'h000101400064000040116a260ad864d3;
    localparam logic [607:0] T1_LIT = {32'h00000072, 64'hFFFF_FFFF_FFFF_FFFF, W0, W1, W2, W3};

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    logic [127:0] fifo_q[$];
    logic         bubble = 1'b0;
    logic         bub_phase = 1'b0;

    logic [127:0] m_words[$];
    logic         m_valid = 1'b0;
    logic [607:0] m_hdr = '0;
    logic [31:0]  m_pkt = 32'd0;

    logic         saw_pop_dut = 1'b0;
    logic         saw_pop_model = 1'b0;
    logic [127:0] saw_word = '0;
    logic         saw_rd = 1'b0;
    logic         saw_rst = 1'b0;
    logic         exp_rd;

    task automatic chk(input string name, input logic [607:0] act, input logic [607:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Byte n of the packet, counting from byte 0 of word 0.
    function automatic logic [7:0] pbyte(input int n);
        logic [127:0] w;
        w = m_words[n / 16];
        return w[127 - 8 * (n % 16) -: 8];
    endfunction

    function automatic logic [607:0] make_hdr();
        logic [15:0] et;
        logic [15:0] sum;
        logic [31:0] len;
        et  = {pbyte(12), pbyte(13)};
        len = 32'd60;
        if (et == 16'h0800) begin
            sum = 16'd14 + {pbyte(16), pbyte(17)};
            len = {16'd0, sum};
        end else if (et == 16'h8847) begin
            sum = 16'd18 + {pbyte(20), pbyte(21)};
            len = {16'd0, sum};
        end
        return {len, 64'hFFFF_FFFF_FFFF_FFFF, m_words[0], m_words[1], m_words[2], m_words[3]};
    endfunction

    // Present the FIFO head, then compare every output against the model.
    always @(negedge clk) begin
        in_empty_i = (fifo_q.size() == 0) || (bubble && bub_phase);
        bub_phase  = ~bub_phase;
        in_data_i  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
        #2;
        exp_rd = dpl_reset_n && !in_empty_i &&
                 !((m_words.size() == HDR_WORDS - 1) && m_valid && !hdr_rd_i);
        chk("in_rd", 608'(in_rd_o), 608'(exp_rd));
        chk("hdr_empty", 608'(hdr_empty_o), 608'(!m_valid));
        chk("beat_cnt", 608'(beat_cnt_o), 608'(m_words.size()));
        chk("pkt_cnt", 608'(pkt_cnt_o), 608'(m_pkt));
        if (m_valid) chk("hdr_data", hdr_data_o, m_hdr);
        saw_pop_dut   = in_rd_o;
        saw_pop_model = exp_rd;
        saw_word      = in_data_i;
        saw_rd        = hdr_rd_i;
        saw_rst       = dpl_reset_n;
    end

    always @(posedge clk) begin
        if (saw_pop_dut && fifo_q.size() != 0) void'(fifo_q.pop_front());
        if (!saw_rst) begin
            m_words.delete();
            m_valid = 1'b0;
            m_pkt   = 32'd0;
        end else if (saw_pop_model && (m_words.size() == HDR_WORDS - 1)) begin
            m_words.push_back(saw_word);
            m_hdr   = make_hdr();
            m_valid = 1'b1;
            m_pkt   = m_pkt + 32'd1;
            m_words.delete();
        end else begin
            if (saw_pop_model) m_words.push_back(saw_word);
            if (saw_rd && m_valid) m_valid = 1'b0;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_pkt(input logic [127:0] a, input logic [127:0] b,
                            input logic [127:0] c, input logic [127:0] d);
        fifo_q.push_back(a);
        fifo_q.push_back(b);
        fifo_q.push_back(c);
        fifo_q.push_back(d);
    endtask

    task automatic consume();
        hdr_rd_i = 1'b1;
        step(1);
        hdr_rd_i = 1'b0;
        step(1);
    endtask

    task automatic wait_pkt(input logic [31:0] target, input int limit);
        int n = 0;
        while (pkt_cnt_o !== target && n < limit) begin
            step(1);
            n++;
        end
        chk("wait_pkt", 608'(pkt_cnt_o), 608'(target));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        step(3);
        chk("rst_hdr_empty", 608'(hdr_empty_o), 608'(1));
        chk("rst_hdr_data", hdr_data_o, 608'(0));
        chk("rst_beat", 608'(beat_cnt_o), 608'(0));
        chk("rst_pkt", 608'(pkt_cnt_o), 608'(0));
        chk("rst_in_rd", 608'(in_rd_o), 608'(0));
        dpl_reset_n = 1'b1;

        // T1 IPv4
        push_pkt(W0, W1, W2, W3);
        step(6);
        chk("t1_hdr", hdr_data_o, T1_LIT);
        chk("t1_pkt", 608'(pkt_cnt_o), 608'(1));
        consume();
        chk("t1_consumed", 608'(hdr_empty_o), 608'(1));

        // T2 ARP and MPLS
        push_pkt(W0A, W1, W2, W3);
        step(6);
        chk("t2_arp_len", 608'(hdr_data_o[607:576]), 608'(32'h0000003c));
        consume();
        push_pkt(W0M, W1M, W2, W3);
        step(6);
        chk("t2_mpls_len", 608'(hdr_data_o[607:576]), 608'(32'h00000076));
        consume();

        // T3 back-to-back with the reader always ready
        hdr_rd_i = 1'b1;
        push_pkt(W0, W1, W2, W3);
        push_pkt(W0A, W1, W2, W3);
        push_pkt(W0M, W1M, W2, W3);
        wait_pkt(32'd4, 20);
        step(4);
        chk("t3_second", 608'(pkt_cnt_o), 608'(5));
        step(4);
        chk("t3_third", 608'(pkt_cnt_o), 608'(6));
        step(2);
        hdr_rd_i = 1'b0;

        // T4 backpressure
        dpl_reset_n = 1'b0;
        step(2);
        dpl_reset_n = 1'b1;
        push_pkt(W0, W1, W2, W3);
        push_pkt(W0, W1, W2, W3);
        step(12);
        chk("t4_fifo_left", 608'(fifo_q.size()), 608'(1));
        chk("t4_in_rd", 608'(in_rd_o), 608'(0));
        chk("t4_pkt1", 608'(pkt_cnt_o), 608'(1));
        chk("t4_beat", 608'(beat_cnt_o), 608'(3));
        hdr_rd_i = 1'b1;
        step(1);
        hdr_rd_i = 1'b0;
        chk("t4_pkt2", 608'(pkt_cnt_o), 608'(2));
        chk("t4_full", 608'(hdr_empty_o), 608'(0));
        chk("t4_hdr", hdr_data_o, T1_LIT);
        chk("t4_fifo_drained", 608'(fifo_q.size()), 608'(0));
        consume();

        // T5 bubbles between every word
        bubble = 1'b1;
        push_pkt(W0, W1, W2, W3);
        step(12);
        chk("t5_hdr", hdr_data_o, T1_LIT);
        chk("t5_pkt", 608'(pkt_cnt_o), 608'(3));
        bubble = 1'b0;
        consume();

        // T6 reset mid-packet
        fifo_q.push_back(W0);
        fifo_q.push_back(W1);
        step(5);
        chk("t6_partial_beat", 608'(beat_cnt_o), 608'(2));
        fifo_q.push_back(W2);
        dpl_reset_n = 1'b0;
        step(1);
        fifo_q.delete();
        dpl_reset_n = 1'b1;
        push_pkt(W0, W1, W2, W3);
        step(8);
        chk("t6_hdr", hdr_data_o, T1_LIT);
        chk("t6_pkt", 608'(pkt_cnt_o), 608'(1));
        step(4);
        chk("t6_pkt_stable", 608'(pkt_cnt_o), 608'(1));
        chk("t6_beat_idle", 608'(beat_cnt_o), 608'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
